clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Controller that sequences a shared up-counter to produce a programmable divided clock (div_clk) and a one-cycle clock-enable pulse (clk_en) per divided period. Divide ratio is loaded through a valid/ready config port; ratio changes take effect only at a period boundary, so div_clk never glitches. Sits in the clock generation/distribution path, feeding local clock enables to downstream logic.

Parameters:
WIDTH, 8, width of divide ratio and internal count
RESET_DIV, 2, divide ratio held after reset (must be >= 2)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
run  in  1  level; 1 = generate divided clock, 0 = stop at end of current period
cfg_valid  in  1  config request
cfg_div  in  WIDTH  requested divide ratio N
cfg_ready  out  1  config can be accepted this cycle
cfg_err  out  1  one-cycle pulse: accepted cfg_div was < 2, ignored
div_clk  out  1  divided clock, registered
clk_en  out  1  registered one-cycle pulse on first cycle of each divided period
busy  out  1  1 when state != IDLE

Behaviour:
- Reset values: state IDLE, active ratio = RESET_DIV, count = 0, no pending config; div_clk=0, clk_en=0, cfg_err=0, busy=0, cfg_ready=1.
- States: IDLE, RUN, DRAIN.
- IDLE: count held at 0, outputs 0. run=1 -> RUN; first RUN cycle has count=0.
- RUN: count increments 0..N-1, then wraps to 0. In a cycle with count c: div_clk = (c < ceil(N/2)), clk_en = (c == 0). Odd N: high phase one cycle longer than low (N=3: 1,1,0).
- Outputs are flops driven from next-state/next-count; no combinational path from inputs to outputs.
- run=0 seen in RUN -> DRAIN; period completes normally. DRAIN with run=1 at any cycle -> back to RUN, no break in sequence. DRAIN at count==N-1 with run=0 -> IDLE; next cycle div_clk=0, count=0.
- Handshake: transfer when cfg_valid & cfg_ready. cfg_ready = 1 in IDLE; in RUN/DRAIN = 1 only when no config pending.
- IDLE transfer: active ratio updated next cycle.
- RUN/DRAIN transfer: stored as pending; applied at wrap (count==N-1 -> 0) so the new period uses the new N; pending cleared, cfg_ready returns 1 in that cycle.
- cfg_div < 2: handshake completes, value discarded, cfg_err pulses next cycle, active/pending unchanged.
- Transfer in the same cycle as wrap: stored as pending, applied at the following wrap.
- Run rising and cfg transfer in same IDLE cycle: new ratio used for first period.
- N = 2^WIDTH-1 supported; count never exceeds N-1.
- rst asserted mid-period: immediate return to reset values; pending config lost.

Optional Feature:
CLK_DIV_PERIOD_CNT_EN defined: extra output period_cnt [15:0], reset 0, increments on every clk_en pulse, wraps 0xFFFF->0. Not defined: port and logic absent.

Decomposition:
- Shared package clk_div_pkg: state encoding (IDLE=0, RUN=1, DRAIN=2, 2-bit), MIN_DIV=2 constant.
- One sub-module: div_counter (WIDTH-wide up counter with enable, synchronous clear, async reset, terminal-count compare against ratio input). Controller owns FSM, config registers, output flops.

Test Plan:
- Reset, run=1, N=RESET_DIV=2 -> div_clk 1,0,1,0...; clk_en on every other cycle starting at first RUN cycle.
- IDLE load N=5, run=1 -> div_clk 1,1,1,0,0 repeating; clk_en once per 5 cycles.
- In RUN with N=4, load N=3 at count=1 -> cfg_ready low until wrap; current period 4 cycles, next period 3 cycles (1,1,0); no short pulse.
- cfg_div=1 -> cfg_err pulse next cycle, ratio unchanged, period length unchanged.
- N=6, drop run at count=2 -> period completes (count reaches 5), then IDLE with div_clk=0, busy=0; re-raise run at count=4 -> uninterrupted output.
- Assert rst at count=3 with config pending -> all outputs 0 immediately; after release, run=1 gives ratio RESET_DIV; with CLK_DIV_PERIOD_CNT_EN, period_cnt back to 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clock divider controller.
//   state_t : controller FSM encoding (IDLE=0, RUN=1, DRAIN=2)
//   MIN_DIV : smallest divide ratio that is accepted on the config port
// ---------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_ctrl_div_counter.sv
// ---------------------------------------------------------------------------
// div_counter
// WIDTH-wide up counter used as the period counter of the divider. It wraps
// to 0 on terminal count, so the count stays in 0..ratio-1.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : advance the count this cycle
//   clr       : synchronous clear (takes priority over en)
//   ratio     : current divide ratio N, terminal count is N-1
//   count_nxt : value the count register loads at the next edge
//   tc        : count == ratio-1 (last cycle of the period)
// ---------------------------------------------------------------------------
module div_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] ratio,
  output logic [WIDTH-1:0] count_nxt,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == ratio - WIDTH'(1));

  // NOTE: every signal driven in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = tc ? '0 : count + WIDTH'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Sequences div_counter to produce a divided clock and a one-cycle clock
// enable on the first cycle of every divided period. Ratio changes made
// while running are held pending and applied only at a period boundary.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   run         : 1 = generate divided clock, 0 = stop at end of period
//   cfg_valid   : config request, cfg_div = requested ratio N
//   cfg_ready   : config can be accepted this cycle
//   cfg_err     : one-cycle pulse, last accepted cfg_div was < 2 (ignored)
//   div_clk     : registered divided clock (high phase ceil(N/2) cycles)
//   clk_en      : registered pulse on the first cycle of each period
//   busy        : controller is not IDLE
//   period_cnt  : (only with CLK_DIV_PERIOD_CNT_EN) count of clk_en pulses
//
// Build option: define CLK_DIV_PERIOD_CNT_EN to add the period_cnt output.
// ---------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             clk_en,
`ifdef CLK_DIV_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ratio, ratio_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [WIDTH-1:0] pend_div, pend_div_nxt;

  logic [WIDTH-1:0] count_nxt;
  logic             tc;
  logic             xfer;
  logic             cfg_ok;
  logic [WIDTH:0]   half_nxt;
  logic             div_clk_d;
  logic             clk_en_d;

  assign busy      = (state != IDLE);
  assign cfg_ready = (state == IDLE) || !pend_valid;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_div >= WIDTH'(MIN_DIV));

  // The counter runs whenever busy and is held at 0 in IDLE, so the first
  // RUN cycle always starts a fresh period at count 0.
  div_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .clr       (!busy),
    .ratio     (ratio),
    .count_nxt (count_nxt),
    .tc        (tc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = DRAIN;
      DRAIN: begin
        if (run)     state_nxt = RUN;
        else if (tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ratio bookkeeping. In IDLE every cycle is a boundary, so an accepted
  // ratio (or one left pending by a transfer in the final wrap cycle of a
  // drain) goes straight to the active register. While running, an accepted
  // ratio waits for the next wrap so div_clk never sees a truncated phase.
  always_comb begin
    ratio_nxt      = ratio;
    pend_valid_nxt = pend_valid;
    pend_div_nxt   = pend_div;
    if (state == IDLE) begin
      if (pend_valid) begin
        ratio_nxt      = pend_div;
        pend_valid_nxt = 1'b0;
      end
      if (xfer && cfg_ok) ratio_nxt = cfg_div;
    end else begin
      if (tc && pend_valid) begin
        ratio_nxt      = pend_div;
        pend_valid_nxt = 1'b0;
      end
      // A transfer only happens with nothing pending, so it cannot collide
      // with the clear above.
      if (xfer && cfg_ok) begin
        pend_valid_nxt = 1'b1;
        pend_div_nxt   = cfg_div;
      end
    end
  end

  // Outputs are computed from next state/count/ratio and registered, so the
  // value seen in a cycle matches that cycle's count.
  assign half_nxt  = ({1'b0, ratio_nxt} + (WIDTH+1)'(1)) >> 1;
  assign div_clk_d = (state_nxt != IDLE) && ({1'b0, count_nxt} < half_nxt);
  assign clk_en_d  = (state_nxt != IDLE) && (count_nxt == '0);

  // NOTE: only control/config flops sit behind the asynchronous reset; there
  // is no storage array here that would need a reset-free implementation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ratio      <= WIDTH'(RESET_DIV);
      pend_valid <= 1'b0;
      pend_div   <= '0;
      div_clk    <= 1'b0;
      clk_en     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ratio      <= ratio_nxt;
      pend_valid <= pend_valid_nxt;
      pend_div   <= pend_div_nxt;
      div_clk    <= div_clk_d;
      clk_en     <= clk_en_d;
      cfg_err    <= xfer && !cfg_ok;
    end
  end

`ifdef CLK_DIV_PERIOD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (clk_en) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl: directed scenarios followed by
// random run/config traffic, all compared against a period-level reference
// model (position in period, active ratio, queue of pending ratios).
// Honors CLK_DIV_PERIOD_CNT_EN like the design.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int WIDTH     = 8;
  localparam int RESET_DIV = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_clk;
  logic             clk_en;
  logic             busy;
`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  clk_div_ctrl #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .div_clk    (div_clk),
    .clk_en     (clk_en),
`ifdef CLK_DIV_PERIOD_CNT_EN
    .period_cnt (period_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy;      // generating periods
  bit m_stop;      // run has dropped, finish this period then stop
  int m_pos;       // cycle index inside current period
  int m_n;         // active ratio
  int m_pend[$];   // ratios waiting for a period boundary
  bit e_err;
  bit e_en;
  int m_pcnt;

  function automatic bit m_ready();
    return !m_busy || (m_pend.size() == 0);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_stop = 0; m_pos = 0; m_n = RESET_DIV;
    m_pend.delete();
    e_err = 0; e_en = 0; m_pcnt = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input int d);
    bit xfer, ok, last;
    xfer   = v && m_ready();
    ok     = (d >= 2);
    m_pcnt = (m_pcnt + int'(e_en)) % 65536;
    e_err  = xfer && !ok;
    if (!m_busy) begin
      if (m_pend.size() != 0) m_n = m_pend.pop_front();
      if (xfer && ok) m_n = d;
      m_pos = 0;
      if (r) begin
        m_busy = 1;
        m_stop = 0;
      end
    end else begin
      last = (m_pos == m_n - 1);
      if (last) begin
        m_pos = 0;
        if (m_pend.size() != 0) m_n = m_pend.pop_front();
      end else begin
        m_pos++;
      end
      if (xfer && ok) m_pend.push_back(d);
      if (r)                 m_stop = 0;
      else if (m_stop && last) m_busy = 0;
      else                   m_stop = 1;
    end
    e_en = m_busy && (m_pos == 0);
  endtask

  task automatic check_outputs();
    check("div_clk", 32'(div_clk), 32'(m_busy && (m_pos < (m_n + 1) / 2)));
    check("clk_en",  32'(clk_en),  32'(e_en));
    check("cfg_err", 32'(cfg_err), 32'(e_err));
    check("busy",    32'(busy),    32'(m_busy));
`ifdef CLK_DIV_PERIOD_CNT_EN
    check("period_cnt", 32'(period_cnt), 32'(m_pcnt));
`endif
  endtask

  // One clock: drive inputs, check cfg_ready mid-cycle, clock, check outputs.
  task automatic step(input bit r, input bit v, input int d);
    run       = r;
    cfg_valid = v;
    cfg_div   = WIDTH'(d);
    @(negedge clk);
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
    @(posedge clk);
    model_step(r, v, d);
    #1;
    check_outputs();
  endtask

  task automatic run_until_pos(input int p);
    for (int k = 0; k < 600 && !(m_busy && m_pos == p); k++) step(1, 0, 0);
    check("reach_pos_busy", 32'(busy), 32'd1);
  endtask

  task automatic go_idle();
    for (int k = 0; k < 600 && m_busy; k++) step(0, 0, 0);
    check("go_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    run = 0; cfg_valid = 0; cfg_div = '0;
    rst = 1'b1;
    #1;
    check("rst_div_clk",   32'(div_clk),   32'd0);
    check("rst_clk_en",    32'(clk_en),    32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
`ifdef CLK_DIV_PERIOD_CNT_EN
    check("rst_period_cnt", 32'(period_cnt), 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [4:0] pat5;
  bit         r_lvl;
  int         sel;
  int         dv;

  initial begin
    rst = 1'b0; run = 0; cfg_valid = 0; cfg_div = '0;
    @(posedge clk);
    #1;
    apply_reset();

    // N = RESET_DIV = 2 straight out of reset.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      check("n2_div_clk", 32'(div_clk), 32'(i % 2 == 0));
    end

    // Load N=5 in IDLE, then run.
    go_idle();
    step(0, 1, 5);
    pat5 = 5'b11100;
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0);
      check("n5_pattern", 32'(div_clk), 32'(pat5[4 - (i % 5)]));
    end

    // N=4, request N=3 at count 1: takes effect only after the wrap.
    go_idle();
    step(1, 1, 4);
    run_until_pos(1);
    step(1, 1, 3);
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Illegal ratio: error pulse, ratio unchanged.
    step(1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);

    // N=6, drop run at count 2 -> drain to IDLE.
    go_idle();
    step(0, 1, 6);
    step(1, 0, 0);
    run_until_pos(2);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    check("drain_idle_div_clk", 32'(div_clk), 32'd0);

    // N=6, drop at count 2, re-raise at count 4 -> no break.
    step(1, 0, 0);
    run_until_pos(2);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // Reset at count 3 with a config pending.
    run_until_pos(1);
    step(1, 1, 9);
    run_until_pos(3);
    apply_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // Large ratio boundary.
    go_idle();
    step(1, 1, 255);
    for (int i = 0; i < 520; i++) step(1, 0, 0);

    // Random traffic.
    r_lvl = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) r_lvl = !r_lvl;
      sel = int'($urandom_range(0, 99));
      if (sel < 8)       dv = int'($urandom_range(0, 1));
      else if (sel < 11) dv = 255;
      else               dv = int'($urandom_range(2, 12));
      step(r_lvl, $urandom_range(0, 9) < 2, dv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
